dip_switch_ctrl: RTL and testbench

Bus-mapped controller for the board's eight active-low 8-bit DIP switch banks. It synchronises and debounces the raw switches, then presents them as two 32-bit stable words in positive logic. It latches per-word change events and raises an interrupt request to CP0. It sits on the system bridge as a peripheral slave; the bridge does base-address decode.

---
 rtl/dip_pkg.sv | 12 +
 rtl/dip_debounce_word.sv | 55 +++++
 rtl/dip_switch_ctrl.sv | 108 ++++++++++
 tb/tb_dip_switch_ctrl.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/dip_pkg.sv
// rtl/dip_pkg.sv - shared register indices and defaults for the DIP switch controller
package dip_pkg;
    localparam logic [2:0] DIP_IDX_W0   = 3'd0;
    localparam logic [2:0] DIP_IDX_W1   = 3'd1;
    localparam logic [2:0] DIP_IDX_CTRL = 3'd2;
    localparam logic [2:0] DIP_IDX_STAT = 3'd3;
    localparam logic [2:0] DIP_IDX_CHG  = 3'd4;

    localparam int CTRL_IE_BIT = 0;

    localparam int unsigned DIP_DEBOUNCE_DEFAULT = 32'd500000;
endpackage

// File: rtl/dip_debounce_word.sv
// rtl/dip_debounce_word.sv - two-flop synchroniser plus counter debounce for one 32-bit word
module dip_debounce_word
    import dip_pkg::*;
#(
    parameter int          CNT_W           = 20,
    parameter int unsigned DEBOUNCE_CYCLES = DIP_DEBOUNCE_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] raw_i,
    output logic [31:0] stable_o,
    output logic        commit_chg_o
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [31:0]      sync1_q, sync2_q;
    logic [31:0]      cand_q, cand_d;
    logic [31:0]      stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            cand_q   <= '0;
            stable_q <= '0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= raw_i;
            sync2_q  <= sync1_q;
            cand_q   <= cand_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    // Once the count saturates it holds, so stable is re-written with an unchanged cand
    always_comb begin
        cand_d       = cand_q;
        cnt_d        = cnt_q;
        stable_d     = stable_q;
        commit_chg_o = 1'b0;
        if (sync2_q != cand_q) begin
            cand_d = sync2_q;
            cnt_d  = '0;
        end else if (cnt_q == CNT_LAST) begin
            stable_d     = cand_q;
            commit_chg_o = (cand_q != stable_q);
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign stable_o = stable_q;
endmodule

// File: rtl/dip_switch_ctrl.sv
// rtl/dip_switch_ctrl.sv - bus-mapped DIP switch controller with change interrupt
// Optional change counter at index 4 enabled by DIP_CHANGE_CNT_EN.
module dip_switch_ctrl
    import dip_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DIP_DEBOUNCE_DEFAULT,
    parameter int          CNT_W           = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Addr,
    input  logic        WE,
    input  logic [31:0] WD,
    output logic [31:0] RD,
    input  logic [7:0]  dip_switch0,
    input  logic [7:0]  dip_switch1,
    input  logic [7:0]  dip_switch2,
    input  logic [7:0]  dip_switch3,
    input  logic [7:0]  dip_switch4,
    input  logic [7:0]  dip_switch5,
    input  logic [7:0]  dip_switch6,
    input  logic [7:0]  dip_switch7,
    output logic        IRQ
);
    logic [2:0]  idx;
    logic [31:0] raw0, raw1, stable0, stable1;
    logic        commit0, commit1;
    logic        ie_q, ie_d;
    logic [1:0]  pend_q, pend_d;
    logic        irq_q;
    logic        unused_bus;

    assign idx        = Addr[4:2];
    assign unused_bus = ^{Addr[31:5], Addr[1:0], WD[31:2]};

    // Switches are active-low; invert so a closed switch reads as 1
    assign raw0 = ~{dip_switch3, dip_switch2, dip_switch1, dip_switch0};
    assign raw1 = ~{dip_switch7, dip_switch6, dip_switch5, dip_switch4};

    dip_debounce_word #(.CNT_W(CNT_W), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_word0 (
        .clk          (clk),
        .reset        (reset),
        .raw_i        (raw0),
        .stable_o     (stable0),
        .commit_chg_o (commit0)
    );

    dip_debounce_word #(.CNT_W(CNT_W), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_word1 (
        .clk          (clk),
        .reset        (reset),
        .raw_i        (raw1),
        .stable_o     (stable1),
        .commit_chg_o (commit1)
    );

    // A set in the same cycle as a W1C clear wins
    always_comb begin
        ie_d   = ie_q;
        pend_d = pend_q;
        if (WE && idx == DIP_IDX_CTRL) ie_d = WD[CTRL_IE_BIT];
        if (WE && idx == DIP_IDX_STAT) pend_d = pend_q & ~WD[1:0];
        pend_d = pend_d | {commit1, commit0};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ie_q   <= 1'b0;
            pend_q <= 2'b00;
            irq_q  <= 1'b0;
        end else begin
            ie_q   <= ie_d;
            pend_q <= pend_d;
            irq_q  <= ie_q & (|pend_q);
        end
    end

    assign IRQ = irq_q;

`ifdef DIP_CHANGE_CNT_EN
    logic [15:0] chg_q, chg_d;

    // A clear coinciding with a commit leaves the count at 1
    always_comb begin
        chg_d = chg_q;
        if (WE && idx == DIP_IDX_CHG) chg_d = '0;
        if (commit0 || commit1) chg_d = chg_d + 16'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) chg_q <= '0;
        else       chg_q <= chg_d;
    end
`endif

    always_comb begin
        RD = '0;
        case (idx)
            DIP_IDX_W0:   RD = stable0;
            DIP_IDX_W1:   RD = stable1;
            DIP_IDX_CTRL: RD = {31'd0, ie_q};
            DIP_IDX_STAT: RD = {30'd0, pend_q};
`ifdef DIP_CHANGE_CNT_EN
            DIP_IDX_CHG:  RD = {16'd0, chg_q};
`endif
            default:      RD = '0;
        endcase
    end
endmodule

// File: tb/tb_dip_switch_ctrl.sv
// tb/tb_dip_switch_ctrl.sv - directed self-checking bench for dip_switch_ctrl
module tb_dip_switch_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] Addr = '0;
    logic        WE = 1'b0;
    logic [31:0] WD = '0;
    logic [31:0] RD;
    logic [7:0]  dip_switch0 = 8'hFF, dip_switch1 = 8'hFF, dip_switch2 = 8'hFF, dip_switch3 = 8'hFF;
    logic [7:0]  dip_switch4 = 8'hFF, dip_switch5 = 8'hFF, dip_switch6 = 8'hFF, dip_switch7 = 8'hFF;
    logic        IRQ;

    int errors = 0;
    int checks = 0;

    dip_switch_ctrl #(.DEBOUNCE_CYCLES(4), .CNT_W(20)) dut (
        .clk         (clk),
        .reset       (reset),
        .Addr        (Addr),
        .WE          (WE),
        .WD          (WD),
        .RD          (RD),
        .dip_switch0 (dip_switch0),
        .dip_switch1 (dip_switch1),
        .dip_switch2 (dip_switch2),
        .dip_switch3 (dip_switch3),
        .dip_switch4 (dip_switch4),
        .dip_switch5 (dip_switch5),
        .dip_switch6 (dip_switch6),
        .dip_switch7 (dip_switch7),
        .IRQ         (IRQ)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rdchk(input string tag, input logic [2:0] idx, input logic [31:0] exp);
        Addr = {27'd0, idx, 2'b00};
        #1;
        chk(tag, RD, exp);
    endtask

    task automatic wr(input logic [2:0] idx, input logic [31:0] data);
        Addr = {27'd0, idx, 2'b00};
        WD   = data;
        WE   = 1'b1;
        @(posedge clk);
        #1;
        WE   = 1'b0;
    endtask

    initial begin
        tick(2);
        reset = 1'b0;
        tick(1);
        rdchk("reset_w0", 3'd0, 32'h0);
        rdchk("reset_stat", 3'd3, 32'h0);
        chk("reset_irq", {31'd0, IRQ}, 32'h0);

        // 1: word-0 change commits on edge 7
        dip_switch0 = 8'hFE;
        for (int i = 1; i <= 10; i++) begin
            tick(1);
            rdchk($sformatf("t1_w0_edge%0d", i), 3'd0, (i >= 7) ? 32'h1 : 32'h0);
        end
        rdchk("t1_stat", 3'd3, 32'h1);

        // 2: 3-cycle glitch on bank 5 never commits
        dip_switch5 = 8'h00;
        tick(3);
        dip_switch5 = 8'hFF;
        tick(12);
        rdchk("t2_w1", 3'd1, 32'h0);
        rdchk("t2_stat", 3'd3, 32'h1);

        // 3: IE set, bank 6 change raises IRQ one cycle after pend[1]
        wr(3'd3, 32'h1);
        wr(3'd2, 32'h1);
        rdchk("t3_ctrl", 3'd2, 32'h1);
        chk("t3_irq_idle", {31'd0, IRQ}, 32'h0);
        dip_switch6 = 8'h7F;
        for (int i = 1; i <= 8; i++) begin
            tick(1);
            chk($sformatf("t3_irq_edge%0d", i), {31'd0, IRQ}, (i >= 8) ? 32'h1 : 32'h0);
            if (i == 7) rdchk("t3_stat", 3'd3, 32'h2);
        end
        rdchk("t3_w1", 3'd1, 32'h00800000);
        wr(3'd3, 32'h2);
        chk("t3_irq_at_clear", {31'd0, IRQ}, 32'h1);
        tick(1);
        chk("t3_irq_after_clear", {31'd0, IRQ}, 32'h0);

        // 4: W1C of pend[0] on the commit edge loses to the set
        dip_switch0 = 8'hFC;
        tick(6);
        wr(3'd3, 32'h1);
        rdchk("t4_stat", 3'd3, 32'h1);
        chk("t4_irq_edge7", {31'd0, IRQ}, 32'h0);
        tick(1);
        chk("t4_irq_edge8", {31'd0, IRQ}, 32'h1);
        tick(1);
        chk("t4_irq_held", {31'd0, IRQ}, 32'h1);
        rdchk("t4_w0", 3'd0, 32'h3);

        // 5: reset at cnt=2 aborts the debounce
        wr(3'd3, 32'h1);
        dip_switch0 = 8'hF0;
        tick(5);
        reset = 1'b1;
        rdchk("t5_rst_w0", 3'd0, 32'h0);
        rdchk("t5_rst_w1", 3'd1, 32'h0);
        rdchk("t5_rst_ctrl", 3'd2, 32'h0);
        chk("t5_rst_irq", {31'd0, IRQ}, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            tick(1);
            if (i == 6) rdchk("t5_w0_edge6", 3'd0, 32'h0);
            if (i == 7) rdchk("t5_w0_edge7", 3'd0, 32'hF);
        end
        rdchk("t5_w1_recommit", 3'd1, 32'h00800000);

`ifdef DIP_CHANGE_CNT_EN
        // 6: three single commits plus one two-word commit
        tick(3);
        wr(3'd4, 32'h0);
        rdchk("t6_chg_clr0", 3'd4, 32'h0);
        dip_switch1 = 8'hFE;
        tick(10);
        dip_switch4 = 8'hFE;
        tick(10);
        dip_switch1 = 8'hFF;
        tick(10);
        dip_switch2 = 8'hFE;
        dip_switch7 = 8'hFE;
        tick(10);
        rdchk("t6_chg", 3'd4, 32'h4);
        wr(3'd4, 32'h0);
        rdchk("t6_chg_clr", 3'd4, 32'h0);
`else
        rdchk("t6_idx4_zero", 3'd4, 32'h0);
`endif

        wr(3'd5, 32'hFFFF_FFFF);
        rdchk("idx5_zero", 3'd5, 32'h0);
        rdchk("idx5_no_side_effect", 3'd2, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
